// File: rtl/elastic_pipe_reg_if.sv
// Handshake bundle between two pipeline stages: an upstream valid/ready/data
// channel into the stage register and a downstream one out of it.
interface elastic_pipe_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Stage register side: consumes the upstream channel, produces the downstream one.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  // Surrounding pipeline side: the mirror image.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer.
// The main register drives the downstream payload; the skid register catches
// the one extra payload accepted while downstream stalls, which lets in_ready
// be a pure decode of registered state. A flush empties both entries and a
// saturating counter records cycles of downstream back-pressure.
module elastic_pipe_reg #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_W        = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  elastic_pipe_reg_if.slave    bus,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic push;
  logic pop;
  logic stalled;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Handshake outputs decode registered state only, so neither in_valid nor
  // out_ready has a combinational path to in_ready/out_valid.
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign stall_count   = cnt_q;

  assign push    = bus.in_valid  & bus.in_ready;
  assign pop     = bus.out_valid & bus.out_ready;
  assign stalled = bus.out_valid & ~bus.out_ready;

  // Occupancy reported as the number of held entries.
  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and payload movement; flush wins over any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Any simultaneous push is dropped; a simultaneous pop already happened.
      state_d = EMPTY;
      main_d  = BUBBLE_VALUE;
      skid_d  = BUBBLE_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = bus.in_data;
          end else if (push) begin
            // Downstream is stalled: park the new payload behind the main one.
            state_d = FULL;
            skid_d  = bus.in_data;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VALUE;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move state.
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VALUE;
          skid_d  = BUBBLE_VALUE;
        end
      endcase
    end
  end

  // Back-pressure counter: flush does not touch it, only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (stalled) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // State, payload and counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VALUE;
      skid_q  <= BUBBLE_VALUE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: reset, streaming, skid fill/drain,
// flush, counter saturation and mid-operation reset.
module tb_elastic_pipe_reg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  elastic_pipe_reg_if #(.WIDTH(WIDTH)) bus ();

  elastic_pipe_reg #(
    .WIDTH       (WIDTH),
    .BUBBLE_VALUE({WIDTH{1'b0}}),
    .CNT_W       (CNT_W)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .bus        (bus),
    .flush      (flush),
    .occupancy  (occupancy),
    .stall_count(stall_count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] data,
                           input logic vld, input logic rdy, input logic [1:0] occ);
    chk({tag, "_data"}, bus.out_data, data);
    chk({tag, "_vld"},  {31'd0, bus.out_valid}, {31'd0, vld});
    chk({tag, "_rdy"},  {31'd0, bus.in_ready},  {31'd0, rdy});
    chk({tag, "_occ"},  {30'd0, occupancy},     {30'd0, occ});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    chk(tag, {28'd0, stall_count}, exp);
  endtask

  task automatic do_reset();
    Rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    // Reset held two cycles while upstream offers a payload.
    Rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEADBEEF;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk_state("reset", 32'h0, 1'b0, 1'b1, 2'd0);
    chk_cnt("reset_cnt", 32'd0);

    // First push after release is accepted.
    Rst = 1'b0;
    tick();
    chk_state("first_push", 32'hDEADBEEF, 1'b1, 1'b1, 2'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk_state("first_pop", 32'h0, 1'b0, 1'b1, 2'd0);
    chk_cnt("first_cnt", 32'd0);

    // Streaming at one payload per cycle.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = i;
      tick();
      chk_state($sformatf("stream%0d", i), i, 1'b1, 1'b1, 2'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk_state("stream_end", 32'h0, 1'b0, 1'b1, 2'd0);
    chk_cnt("stream_cnt", 32'd0);

    // Back-pressure fills the skid register.
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA0;
    tick();
    chk_state("bp_a", 32'hA0, 1'b1, 1'b1, 2'd1);
    chk_cnt("bp_a_cnt", 32'd0);
    bus.in_data = 32'hB0;
    tick();
    chk_state("bp_full", 32'hA0, 1'b1, 1'b0, 2'd2);
    chk_cnt("bp_full_cnt", 32'd1);
    bus.in_data = 32'hC0;
    tick();
    chk_state("bp_hold1", 32'hA0, 1'b1, 1'b0, 2'd2);
    chk_cnt("bp_hold1_cnt", 32'd2);
    tick();
    chk_state("bp_hold2", 32'hA0, 1'b1, 1'b0, 2'd2);
    chk_cnt("bp_hold2_cnt", 32'd3);
    bus.out_ready = 1'b1;
    tick();
    chk_state("drain_b", 32'hB0, 1'b1, 1'b1, 2'd1);
    chk_cnt("drain_cnt", 32'd3);
    tick();
    chk_state("drain_c", 32'hC0, 1'b1, 1'b1, 2'd1);
    bus.in_valid = 1'b0;
    tick();
    chk_state("drain_end", 32'h0, 1'b0, 1'b1, 2'd0);

    // Flush while full with a simultaneous push of 0x55.
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h66;
    tick();
    bus.in_data = 32'h77;
    tick();
    chk_state("fl_full", 32'h66, 1'b1, 1'b0, 2'd2);
    flush       = 1'b1;
    bus.in_data = 32'h55;
    #1;
    chk("fl_rdy_pre", {31'd0, bus.in_ready}, 32'd0);
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk_state("fl_after", 32'h0, 1'b0, 1'b1, 2'd0);
    chk_cnt("fl_cnt", 32'd2);
    bus.out_ready = 1'b1;
    tick();
    chk_state("fl_no55", 32'h0, 1'b0, 1'b1, 2'd0);

    // Saturation of the 4-bit stall counter.
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h99;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk_cnt("sat_14", 32'd14);
    tick();
    chk_cnt("sat_15", 32'd15);
    for (int i = 0; i < 5; i++) tick();
    chk_cnt("sat_20", 32'd15);
    chk_state("sat_hold", 32'h99, 1'b1, 1'b1, 2'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk_cnt("sat_flush", 32'd15);
    chk_state("sat_flush_st", 32'h0, 1'b0, 1'b1, 2'd0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk_cnt("sat_rst", 32'd0);

    // Reset in the middle of a full, stalled stage with out_ready high.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h11;
    tick();
    bus.in_data = 32'h22;
    tick();
    chk_state("mid_full", 32'h11, 1'b1, 1'b0, 2'd2);
    Rst           = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data   = 32'h33;
    tick();
    chk_state("mid_rst", 32'h0, 1'b0, 1'b1, 2'd0);
    chk_cnt("mid_rst_cnt", 32'd0);
    Rst          = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk_state("mid_after", 32'h0, 1'b0, 1'b1, 2'd0);
    chk_cnt("mid_after_cnt", 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised successor to the fixed if_id / id_ex stage registers.
- Single pipeline stage register of arbitrary WIDTH with a valid/ready handshake on both sides, plus a 2-entry skid buffer so upstream ready is registered.
- Synchronous flush inserts a bubble; a saturating stall counter exposes back-pressure.
- Instantiated between pipeline stages of the datapath (IF/ID, ID/EX, EX/MEM, MEM/WB) with the control and data fields concatenated into in_data.

Parameters:
- WIDTH, 32: payload width in bits (concatenated data plus control fields).
- BUBBLE_VALUE, {WIDTH{1'b0}}: value driven on out_data when the stage is empty (NOP / all control deasserted).
- CNT_W, 16: width of stall_count.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept; registered, depends only on internal state.
- in_data  input  WIDTH  upstream payload.
- flush  input  1  synchronous kill of all held payloads (branch taken / jump).
- out_valid  output  1  out_data holds a valid payload.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload to the next stage.
- occupancy  output  2  entries held: 0, 1 or 2.
- stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Interface fixed: one clock, Clk; reset Rst is synchronous and active-high. All state updates occur on the rising edge of Clk.
- Storage: main register (drives out_data), skid register, and a state in {EMPTY, ONE, FULL}. occupancy = 0 / 1 / 2 respectively.
- Handshakes: push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - Neither output has a combinational path from in_valid or out_ready.
- Reset (Rst=1, sampled at the clock edge):
  - state = EMPTY, so out_valid=0, in_ready=1, occupancy=0.
  - main = skid = BUBBLE_VALUE, so out_data = BUBBLE_VALUE.
  - stall_count = 0.
  - Reset overrides flush and any handshake, including in the middle of an operation.
- Transitions, when not flushing:
  - EMPTY: push -> ONE, main <= in_data. Otherwise stay.
  - ONE, push & pop -> ONE, main <= in_data.
  - ONE, push & !pop -> FULL, skid <= in_data; main unchanged.
  - ONE, pop & !push -> EMPTY, main <= BUBBLE_VALUE.
  - ONE, no handshake -> hold.
  - FULL (in_ready=0, so no push): pop -> ONE, main <= skid, skid <= BUBBLE_VALUE. Otherwise hold.
- Ordering and throughput:
  - Strict FIFO order. The skid entry always leaves after the main entry.
  - Latency: in_data accepted at edge N appears on out_data after edge N when the stage was EMPTY, or in ONE with a simultaneous pop.
  - Sustained throughput: 1 payload per cycle while out_ready=1.
- Flush (flush=1, Rst=0):
  - Next state = EMPTY; main = skid = BUBBLE_VALUE.
  - A simultaneous push is discarded.
  - A simultaneous pop counts as completed: downstream consumed it, and there is no replay.
  - in_ready in the flush cycle follows the pre-flush state; it is 1 again the cycle after.
- stall_count:
  - Increments by 1 each cycle out_valid & !out_ready, saturating at 2^CNT_W-1 (no wrap).
  - Unaffected by flush; cleared only by Rst.
- Payload is opaque: no arithmetic on in_data; width is exactly WIDTH with no truncation or extension.
- out_data equals BUBBLE_VALUE exactly when out_valid=0.

Test Plan:
- Reset: assert Rst 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_count=0. Release -> first push accepted.
- Streaming: out_ready=1, push 32'h1..32'h8 on consecutive cycles -> out_data 1..8 on consecutive cycles, each one cycle after its push; in_ready stays 1; stall_count stays 0.
- Back-pressure fills the skid:
  - Push A=32'hA0, B=32'hB0 with out_ready=0 -> occupancy=2, in_ready=0, out_data=A0. Offered C=32'hC0 is not accepted.
  - Hold for 3 cycles -> stall_count increments each stalled cycle (reaching 3 at the end of the hold).
  - Raise out_ready -> outputs A0, B0, C0 in order; occupancy returns to 1 then 0 (or stays 1 while C streams).
- Flush while FULL with a simultaneous push of 32'h55 -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VALUE, in_ready=1; 32'h55 never appears.
- Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_count=15, no wrap. Flush -> stays 15. Rst -> 0.
- Reset mid-operation: FULL with payloads 32'h11, 32'h22, then assert Rst with out_ready=1 -> no pop counted after reset; state EMPTY and outputs equal the reset values.
